// File: rtl/sprite_palette_lut.sv
// sprite_palette_lut
//   Sprite colour-index to RGB lookup. NUM_PAL independent palettes of
//   2^INDEX_W entries each, two-cycle lookup pipeline, optional hit-flash.
//
//   Optional feature macro: SPRITE_PALETTE_FLASH_EN
//     defined   -> flash counter and white-out of opaque pixels
//     undefined -> flash_start/frame_tick ignored, flash_active tied low
//
// Ports
//   Clk, Reset                   clock, synchronous active-high reset
//   wr_en/wr_pal/wr_index/wr_rgb palette write {R,G,B}
//   rd_valid_in/rd_pal/rd_index  lookup request
//   flash_start, frame_tick      hit-flash trigger, per-frame pulse
//   rd_valid_out, red/green/blue lookup result (held while not valid)
//   transparent                  index was TRANSPARENT_IDX
//   flash_active                 flash counter nonzero (registered)
module sprite_palette_lut #(
  parameter int INDEX_W         = 4,
  parameter int NUM_PAL         = 4,
  parameter int CW              = 4,
  parameter int TRANSPARENT_IDX = 0,
  parameter int FLASH_FRAMES    = 8
) (
  input  logic                       Clk,
  input  logic                       Reset,
  input  logic                       wr_en,
  input  logic [$clog2(NUM_PAL)-1:0] wr_pal,
  input  logic [INDEX_W-1:0]         wr_index,
  input  logic [3*CW-1:0]            wr_rgb,
  input  logic                       rd_valid_in,
  input  logic [$clog2(NUM_PAL)-1:0] rd_pal,
  input  logic [INDEX_W-1:0]         rd_index,
  input  logic                       flash_start,
  input  logic                       frame_tick,
  output logic                       rd_valid_out,
  output logic [CW-1:0]              red,
  output logic [CW-1:0]              green,
  output logic [CW-1:0]              blue,
  output logic                       transparent,
  output logic                       flash_active
);

  localparam int PW    = $clog2(NUM_PAL);
  localparam int AW    = PW + INDEX_W;
  localparam int DEPTH = 1 << AW;
  localparam int RGBW  = 3 * CW;
  localparam logic [INDEX_W-1:0] TIDX = INDEX_W'(TRANSPARENT_IDX);

  logic [RGBW-1:0]  mem_q [DEPTH];
  logic [DEPTH-1:0] loaded_q;

  logic [AW-1:0] wr_addr;
  logic [AW-1:0] rd_addr;
  assign wr_addr = {wr_pal, wr_index};
  assign rd_addr = {rd_pal, rd_index};

  // Colour storage is deliberately not reset; the loaded bits mask stale data.
  always_ff @(posedge Clk) begin
    if (!Reset && wr_en) begin
      mem_q[wr_addr] <= wr_rgb;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      loaded_q <= '0;
    end else if (wr_en) begin
      loaded_q[wr_addr] <= 1'b1;
    end
  end

  // Stage 1: array read. A same-edge write lands after this read, so a
  // colliding lookup sees the pre-write contents.
  logic            s1_valid_q;
  logic            s1_trans_q;
  logic            s1_loaded_q;
  logic [RGBW-1:0] s1_rgb_q;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      s1_valid_q  <= 1'b0;
      s1_trans_q  <= 1'b0;
      s1_loaded_q <= 1'b0;
      s1_rgb_q    <= '0;
    end else begin
      s1_valid_q  <= rd_valid_in;
      s1_trans_q  <= (rd_index == TIDX);
      s1_loaded_q <= loaded_q[rd_addr];
      s1_rgb_q    <= mem_q[rd_addr];
    end
  end

  // Flash counter
  logic flash_active_q;

`ifdef SPRITE_PALETTE_FLASH_EN
  logic [7:0] flash_cnt_q;
  logic [7:0] flash_cnt_d;

  // Load beats decrement when both arrive in the same cycle.
  always_comb begin
    flash_cnt_d = flash_cnt_q;
    if (flash_start) begin
      flash_cnt_d = 8'(FLASH_FRAMES);
    end else if (frame_tick && (flash_cnt_q != 8'd0)) begin
      flash_cnt_d = flash_cnt_q - 8'd1;
    end
  end

  // flash_active tracks the counter value it is registered alongside.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      flash_cnt_q    <= 8'd0;
      flash_active_q <= 1'b0;
    end else begin
      flash_cnt_q    <= flash_cnt_d;
      flash_active_q <= (flash_cnt_d != 8'd0);
    end
  end
`else
  logic unused_flash_inputs;
  assign unused_flash_inputs = flash_start ^ frame_tick;
  assign flash_active_q      = 1'b0;
`endif

  // Stage 2: colour selection. Flash is sampled here, so pixels already in
  // flight when a flash starts are whitened too.
  logic [RGBW-1:0] pix_d;

  always_comb begin
    pix_d = '0;
    if (s1_trans_q) begin
      pix_d = '0;
    end else if (flash_active_q) begin
      pix_d = '1;
    end else if (s1_loaded_q) begin
      pix_d = s1_rgb_q;
    end
  end

  logic            out_valid_q;
  logic [RGBW-1:0] out_rgb_q;
  logic            out_trans_q;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      out_valid_q <= 1'b0;
      out_rgb_q   <= '0;
      out_trans_q <= 1'b0;
    end else begin
      out_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        out_rgb_q   <= pix_d;
        out_trans_q <= s1_trans_q;
      end
    end
  end

  assign rd_valid_out = out_valid_q;
  assign red          = out_rgb_q[RGBW-1 -: CW];
  assign green        = out_rgb_q[2*CW-1 -: CW];
  assign blue         = out_rgb_q[CW-1:0];
  assign transparent  = out_trans_q;
  assign flash_active = flash_active_q;

endmodule

// File: tb/tb_sprite_palette_lut.sv
module tb_sprite_palette_lut;

  localparam int INDEX_W         = 4;
  localparam int NUM_PAL         = 4;
  localparam int CW              = 4;
  localparam int TRANSPARENT_IDX = 0;
  localparam int FLASH_FRAMES    = 8;
  localparam int ENTRIES         = NUM_PAL * (1 << INDEX_W);

  logic        Clk;
  logic        Reset;
  logic        wr_en;
  logic [1:0]  wr_pal;
  logic [3:0]  wr_index;
  logic [11:0] wr_rgb;
  logic        rd_valid_in;
  logic [1:0]  rd_pal;
  logic [3:0]  rd_index;
  logic        flash_start;
  logic        frame_tick;
  logic        rd_valid_out;
  logic [3:0]  red;
  logic [3:0]  green;
  logic [3:0]  blue;
  logic        transparent;
  logic        flash_active;

  sprite_palette_lut #(
    .INDEX_W(INDEX_W), .NUM_PAL(NUM_PAL), .CW(CW),
    .TRANSPARENT_IDX(TRANSPARENT_IDX), .FLASH_FRAMES(FLASH_FRAMES)
  ) dut (
    .Clk(Clk), .Reset(Reset),
    .wr_en(wr_en), .wr_pal(wr_pal), .wr_index(wr_index), .wr_rgb(wr_rgb),
    .rd_valid_in(rd_valid_in), .rd_pal(rd_pal), .rd_index(rd_index),
    .flash_start(flash_start), .frame_tick(frame_tick),
    .rd_valid_out(rd_valid_out), .red(red), .green(green), .blue(blue),
    .transparent(transparent), .flash_active(flash_active)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    int          due;
    bit          trans;
    bit          loaded;
    logic [11:0] rgb;
  } exp_t;

  exp_t        sb[$];
  logic [11:0] m_mem [ENTRIES];
  bit          m_ld  [ENTRIES];
  int          m_cnt;
  bit          m_fa;
  bit          m_fa_prev;
  int          cyc;
  bit          started;
  logic [11:0] hold_rgb;
  bit          hold_trans;
  int          tests;
  int          fails;

  // Drive one clock cycle of stimulus and advance the reference model.
  task automatic cycle(input bit rst, input bit we, input int wp, input int wi,
                       input logic [11:0] wrgb, input bit re, input int rp,
                       input int ri, input bit fs, input bit ft);
    exp_t e;
    int   wpi;
    int   wii;
    int   rpi;
    int   rii;
    wpi = wp; wii = wi; rpi = rp; rii = ri;
    Reset = rst; wr_en = we; wr_pal = wpi[1:0]; wr_index = wii[3:0]; wr_rgb = wrgb;
    rd_valid_in = re; rd_pal = rpi[1:0]; rd_index = rii[3:0];
    flash_start = fs; frame_tick = ft;
    if (re && !rst) begin
      e.due    = cyc + 2;
      e.trans  = (ri == TRANSPARENT_IDX);
      e.loaded = m_ld[rp * 16 + ri];
      e.rgb    = m_mem[rp * 16 + ri];
      sb.push_back(e);
    end
    @(posedge Clk);
    #1;
    cyc++;
    if (rst) begin
      for (int k = 0; k < ENTRIES; k++) m_ld[k] = 1'b0;
      sb.delete();
      hold_rgb   = '0;
      hold_trans = 1'b0;
    end else if (we) begin
      m_mem[wp * 16 + wi] = wrgb;
      m_ld[wp * 16 + wi]  = 1'b1;
    end
    m_fa_prev = m_fa;
`ifdef SPRITE_PALETTE_FLASH_EN
    if (rst)                  m_cnt = 0;
    else if (fs)              m_cnt = FLASH_FRAMES;
    else if (ft && m_cnt != 0) m_cnt = m_cnt - 1;
    m_fa = (m_cnt != 0);
`else
    m_cnt = 0;
    m_fa  = 1'b0;
`endif
    Reset = 1'b0; wr_en = 1'b0; rd_valid_in = 1'b0;
    flash_start = 1'b0; frame_tick = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cycle(0, 0, 0, 0, 12'h0, 0, 0, 0, 0, 0);
  endtask

  task automatic wr(input int p, input int i, input logic [11:0] c);
    cycle(0, 1, p, i, c, 0, 0, 0, 0, 0);
  endtask

  task automatic rd(input int p, input int i);
    cycle(0, 0, 0, 0, 12'h0, 1, p, i, 0, 0);
  endtask

  // Scoreboard: outputs sampled mid-cycle, compared against queued results.
  exp_t        mon_e;
  logic [11:0] mon_rgb;
  bit          mon_trans;
  always @(negedge Clk) begin
    if (started) begin
      if (rd_valid_out) begin
        tests++;
        if (sb.size() == 0) begin
          fails++;
          $display("FAIL unexpected_valid cyc=%0d got rd_valid_out=1 expected 0", cyc);
        end else begin
          mon_e = sb.pop_front();
          if (mon_e.trans) begin
            mon_rgb = 12'h000; mon_trans = 1'b1;
          end else if (m_fa_prev) begin
            mon_rgb = 12'hFFF; mon_trans = 1'b0;
          end else if (!mon_e.loaded) begin
            mon_rgb = 12'h000; mon_trans = 1'b0;
          end else begin
            mon_rgb = mon_e.rgb; mon_trans = 1'b0;
          end
          if ({red, green, blue, transparent} !== {mon_rgb, mon_trans} || cyc != mon_e.due) begin
            fails++;
            $display("FAIL lookup cyc=%0d got rgb=%h trans=%b expected rgb=%h trans=%b at cyc %0d",
                     cyc, {red, green, blue}, transparent, mon_rgb, mon_trans, mon_e.due);
          end
          hold_rgb   = mon_rgb;
          hold_trans = mon_trans;
        end
      end else begin
        if (sb.size() != 0 && sb[0].due <= cyc) begin
          tests++;
          fails++;
          $display("FAIL missing_valid cyc=%0d got rd_valid_out=0 expected 1", cyc);
          mon_e = sb.pop_front();
        end
        tests++;
        if ({red, green, blue, transparent} !== {hold_rgb, hold_trans}) begin
          fails++;
          $display("FAIL hold cyc=%0d got rgb=%h trans=%b expected rgb=%h trans=%b",
                   cyc, {red, green, blue}, transparent, hold_rgb, hold_trans);
        end
      end
    end
  end

  task automatic test_reset();
    cycle(1, 1, 0, 1, 12'hABC, 1, 0, 1, 1, 0);
    cycle(1, 0, 0, 0, 12'h0, 0, 0, 0, 0, 0);
    started = 1'b1;
    tests++;
    if ({rd_valid_out, red, green, blue, transparent, flash_active} !== 15'h0) begin
      fails++;
      $display("FAIL reset_state got valid=%b rgb=%h trans=%b flash=%b expected all 0",
               rd_valid_out, {red, green, blue}, transparent, flash_active);
    end
    idle(3);
  endtask

  task automatic test_unloaded();
    rd(1, 5);
    tests++;
    if (rd_valid_out !== 1'b0) begin
      fails++;
      $display("FAIL unloaded_latency got rd_valid_out=%b one cycle after request expected 0", rd_valid_out);
    end
    idle(3);
  endtask

  task automatic test_write_read();
    wr(2, 3, 12'hD98);
    rd(2, 3);
    rd(1, 3);
    cycle(0, 1, 2, 3, 12'h111, 1, 2, 3, 0, 0);
    rd(2, 3);
    idle(3);
    tests++;
    if ({red, green, blue} !== 12'h111) begin
      fails++;
      $display("FAIL write_visible got rgb=%h expected 111", {red, green, blue});
    end
  endtask

  task automatic test_transparent();
    wr(0, 0, 12'hF0F);
    rd(0, 0);
    rd(1, 0);
    idle(3);
    tests++;
    if ({transparent, red, green, blue} !== 13'h1000) begin
      fails++;
      $display("FAIL transparent got trans=%b rgb=%h expected trans=1 rgb=000",
               transparent, {red, green, blue});
    end
  endtask

`ifdef SPRITE_PALETTE_FLASH_EN
  task automatic test_flash();
    cycle(0, 0, 0, 0, 12'h0, 0, 0, 0, 1, 0);
    tests++;
    if (flash_active !== 1'b1) begin
      fails++;
      $display("FAIL flash_start got flash_active=%b expected 1", flash_active);
    end
    rd(2, 3);
    rd(0, 0);
    rd(1, 7);
    idle(3);
    for (int t = 1; t <= 8; t++) begin
      cycle(0, 0, 0, 0, 12'h0, 0, 0, 0, 0, 1);
      tests++;
      if (flash_active !== (t < 8)) begin
        fails++;
        $display("FAIL flash_tick%0d got flash_active=%b expected %b", t, flash_active, (t < 8));
      end
      idle(1);
    end
    rd(2, 3);
    idle(3);
    tests++;
    if ({red, green, blue} !== 12'h111) begin
      fails++;
      $display("FAIL flash_over got rgb=%h expected 111", {red, green, blue});
    end
    // Restart on the same cycle as tick 4, then eight more ticks to expire.
    cycle(0, 0, 0, 0, 12'h0, 0, 0, 0, 1, 0);
    for (int t = 1; t <= 3; t++) cycle(0, 0, 0, 0, 12'h0, 0, 0, 0, 0, 1);
    cycle(0, 0, 0, 0, 12'h0, 0, 0, 0, 1, 1);
    for (int t = 1; t <= 8; t++) begin
      cycle(0, 0, 0, 0, 12'h0, 0, 0, 0, 0, 1);
      tests++;
      if (flash_active !== (t < 8)) begin
        fails++;
        $display("FAIL flash_restart_tick%0d got flash_active=%b expected %b", t, flash_active, (t < 8));
      end
    end
    // Flash triggered alongside a lookup still whitens it at stage 2.
    cycle(0, 0, 0, 0, 12'h0, 1, 2, 3, 1, 0);
    idle(3);
    for (int t = 1; t <= 8; t++) cycle(0, 0, 0, 0, 12'h0, 0, 0, 0, 0, 1);
    idle(2);
  endtask
`else
  task automatic test_flash_disabled();
    cycle(0, 0, 0, 0, 12'h0, 0, 0, 0, 1, 1);
    idle(2);
    tests++;
    if (flash_active !== 1'b0) begin
      fails++;
      $display("FAIL flash_disabled got flash_active=%b expected 0", flash_active);
    end
    rd(2, 3);
    idle(3);
    tests++;
    if ({red, green, blue} !== 12'h111) begin
      fails++;
      $display("FAIL flash_disabled_colour got rgb=%h expected 111", {red, green, blue});
    end
  endtask
`endif

  task automatic test_back_to_back();
    logic [11:0] c;
    for (int i = 0; i < 16; i++) begin
      c = {4'(i), 4'(15 - i), 4'(i ^ 5)};
      wr(3, i, c);
    end
    for (int i = 0; i < 16; i++) rd(3, i);
    idle(3);
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL back_to_back_drain got %0d pending expected 0", sb.size());
    end
    for (int i = 1; i <= 6; i++) rd(3, i);
    cycle(1, 1, 3, 9, 12'h555, 1, 3, 9, 0, 0);
    tests++;
    if (rd_valid_out !== 1'b0) begin
      fails++;
      $display("FAIL reset_midstream got rd_valid_out=%b expected 0", rd_valid_out);
    end
    idle(4);
    rd(3, 4);
    idle(3);
  endtask

  initial begin
    tests = 0; fails = 0; cyc = 0; started = 1'b0;
    m_cnt = 0; m_fa = 1'b0; m_fa_prev = 1'b0;
    hold_rgb = '0; hold_trans = 1'b0;
    for (int k = 0; k < ENTRIES; k++) begin
      m_mem[k] = 12'h000;
      m_ld[k]  = 1'b0;
    end
    Reset = 1'b1; wr_en = 1'b0; wr_pal = '0; wr_index = '0; wr_rgb = '0;
    rd_valid_in = 1'b0; rd_pal = '0; rd_index = '0;
    flash_start = 1'b0; frame_tick = 1'b0;

    test_reset();
    test_unloaded();
    test_write_read();
    test_transparent();
`ifdef SPRITE_PALETTE_FLASH_EN
    test_flash();
`else
    test_flash_disabled();
`endif
    test_back_to_back();

    idle(4);
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL final_drain got %0d pending expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/sprite_palette_lut.md
SPRITE_PALETTE_LUT -- requirements
Module: sprite_palette_lut

Interface
REQ-001 SHALL provide parameter INDEX_W, default 4, pixel colour-index width; each palette holds 2^INDEX_W entries.
REQ-002 SHALL provide parameter NUM_PAL, default 4, number of independent palettes (power of two, >=2).
REQ-003 SHALL provide parameter CW, default 4, bits per colour channel.
REQ-004 SHALL provide parameter TRANSPARENT_IDX, default 0, index treated as transparent in every palette.
REQ-005 SHALL provide parameter FLASH_FRAMES, default 8, frames a hit-flash lasts (1..255).
REQ-006 SHALL have ports, clock and reset first: Clk in 1 system clock; Reset in 1 synchronous active-high reset.
REQ-007 wr_en in 1 palette write strobe; wr_pal in log2(NUM_PAL) target palette; wr_index in INDEX_W target entry; wr_rgb in 3*CW colour {R,G,B}.
REQ-008 rd_valid_in in 1 lookup request; rd_pal in log2(NUM_PAL) palette select; rd_index in INDEX_W pixel index.
REQ-009 flash_start in 1 hit-flash trigger pulse; frame_tick in 1 one-cycle pulse per video frame.
REQ-010 rd_valid_out out 1; red, green, blue out CW each; transparent out 1; flash_active out 1.

Function
REQ-011 Lookup latency SHALL be exactly 2 cycles: request in cycle N gives rd_valid_out=1 and data in cycle N+2; one lookup per cycle, no stalls.
REQ-012 Outputs SHALL hold their last values while rd_valid_out=0.
REQ-013 Write SHALL store wr_rgb at (wr_pal, wr_index) on the rising edge when wr_en=1, and set that entry's loaded bit.
REQ-014 A lookup of an entry whose loaded bit is 0 SHALL return red=green=blue=0, transparent=0.
REQ-015 Same-cycle write and read of the same entry SHALL return the old (pre-write) contents; the new value is visible to reads issued from the next cycle.
REQ-016 rd_index==TRANSPARENT_IDX SHALL give transparent=1 and red=green=blue=0 regardless of contents, palette, or flash state.
REQ-017 Flash counter (8 bits) SHALL load FLASH_FRAMES on flash_start and decrement by one on each frame_tick while nonzero; it SHALL not wrap below zero.
REQ-018 flash_start and frame_tick in the same cycle: load SHALL win, no decrement that cycle; flash_start during an active flash SHALL restart at FLASH_FRAMES.
REQ-019 flash_active SHALL equal (counter != 0), registered.
REQ-020 While flash_active is 1 when a pixel reaches stage 2, non-transparent pixels SHALL output all-ones on every channel (white); loaded bit ignored.
REQ-021 Flash state SHALL be sampled in stage 2, so flash affects a pixel issued before the flash if it is still in flight.

Reset
REQ-022 Reset SHALL clear rd_valid_out, red, green, blue, transparent, flash_active, flash counter, both pipeline valid bits, and all loaded bits.
REQ-023 Palette colour storage SHALL not be reset; reset-cleared loaded bits make it read as zero.
REQ-024 Reset mid-lookup SHALL drop in-flight requests: no rd_valid_out pulse for requests issued in the 2 cycles before reset deasserts.
REQ-025 Writes and requests SHALL be ignored in any cycle Reset=1.

Configuration
REQ-026 Macro SPRITE_PALETTE_FLASH_EN SHALL compile in REQ-017..REQ-021.
REQ-027 Without SPRITE_PALETTE_FLASH_EN: flash_start and frame_tick ignored, flash_active tied 0, no counter logic; colours pass unmodified; latency unchanged at 2.

Verification
REQ-028 Reset, then read (pal 1, idx 5) with nothing loaded -> cycle+2 rd_valid_out=1, RGB=0,0,0, transparent=0.
REQ-029 Write 0xD98 to (2,3), next cycle read (2,3) then (1,3) -> RGB D,9,8, then 0,0,0; same-cycle write 0x111 and read of (2,3) -> D,9,8.
REQ-030 Load 0xF0F at (0,0), read index 0 -> transparent=1, RGB 0,0,0; repeat with flash active -> same.
REQ-031 (FLASH_EN) flash_start, 8 frame_ticks -> flash_active high exactly until the 8th tick; opaque reads F,F,F meanwhile, stored colour after; flash_start on the same cycle as tick 4 -> counter back to 8.
REQ-032 Back-to-back reads of 16 indices -> 16 consecutive rd_valid_out cycles, correct order; Reset asserted mid-stream -> no further valid output.
